mem_port_sched: RTL
===================

Name: mem_port_sched

Overview:
- Schedules a single shared memory port between the instruction-fetch unit and the load/store path of the multi-cycle RISC-V core.
- One transaction is outstanding at a time: request, then accept, then response.
- Data accesses have priority. A starvation counter guarantees that fetch eventually wins.
- Sits between the core's fetch/LSU logic and the unified instruction/data memory.

Parameters:
- XLEN, 32, address/data width.
- STARVE_MAX, 4, number of consecutive data grants made while fetch waits before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  XLEN  fetch address
- if_gnt  out  1  fetch request accepted by memory (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  XLEN  fetch data
- d_req  in  1  data request; held with payload until d_gnt
- d_we  in  1  1 = store
- d_size  in  3  access size, same encoding as the core's memsize
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_rvalid  out  1  load data / store ack valid (1-cycle pulse)
- d_rdata  out  XLEN  load data
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_size  out  3  memory access size
- m_addr  out  XLEN  memory address
- m_wdata  out  XLEN  memory write data
- m_ready  in  1  memory accepts request this cycle
- m_rvalid  in  1  memory response; one per accepted request, reads and writes alike
- m_rdata  in  XLEN  memory read data

Behaviour:
- FSM states: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D. Clock and reset are fixed: one clock clk; synchronous active-low reset rst_n.
- Reset (rst_n=0 at a clk edge) forces:
  - state IDLE, starve_cnt 0;
  - all gnt/rvalid outputs 0, m_req 0, m_we 0;
  - m_addr, m_wdata, m_size, if_rdata, d_rdata all 0.
- IDLE arbitration (combinational, same cycle):
  - If d_req and not (if_req and starve_cnt==STARVE_MAX), data wins; else if if_req, fetch wins; else stay IDLE.
  - The winner's payload drives m_* and m_req=1 in the same cycle. Fetch drives m_we=0 and m_size=word encoding.
- Accept: m_req & m_ready in any cycle.
  - The winner's gnt pulses that cycle.
  - Next state is WAIT_I or WAIT_D.
- Not accepted: m_req & !m_ready.
  - Next state is REQ_I or REQ_D; the winner is latched.
  - m_req stays 1 and the payload is re-muxed from the same requester until m_ready.
  - A new request from the other side does not preempt.
- WAIT_x:
  - m_req=0.
  - On m_rvalid, the owner's rvalid pulses; rdata = m_rdata in the same cycle (combinational pass-through, held at last value otherwise); next state IDLE.
  - No new request issues in that cycle. Minimum issue interval is accept cycle + 1 response cycle + 1 IDLE cycle.
- Latency: request in IDLE with m_ready=1 gives gnt in cycle 0; rvalid in the cycle m_rvalid arrives (earliest cycle 1).
- Starvation counter:
  - On each data accept while if_req=1: starve_cnt++ (saturating at STARVE_MAX).
  - On fetch accept: starve_cnt=0.
  - Reset to 0 on rst_n=0.
- Boundaries:
  - m_rvalid in IDLE or REQ_x is ignored; no rvalid output.
  - m_ready while m_req=0 is ignored.
  - Requester drops req before gnt: protocol violation; the design keeps m_req asserted (bench must not do this).
  - Reset mid-transaction aborts it; a late m_rvalid after reset is discarded.
  - Both req high with starve_cnt<STARVE_MAX: data wins.
  - STARVE_MAX reached with fetch waiting: fetch wins even if d_req=1.

Decomposition:
- Shared package (core pkg): sched_state_t enum; the memsize encodings (byte/half/word, signed/unsigned); the constant for the word size encoding.
- One sub-module, sched_starve_cnt: a saturating counter with inc/clr inputs and a hit output. It is parameterised by STARVE_MAX.
- FSM and payload mux stay in mem_port_sched.

Test Plan:
- Reset and IDLE check. Stimulus: rst_n=0 for 2 cycles with if_req=1 and m_rvalid=1. Required: all outputs 0, no gnt. After release, if_gnt in the first cycle (m_ready=1).
- Fetch read. Stimulus: if_req, if_addr=0x100, m_ready=1, m_rvalid=1 one cycle later with m_rdata=0xDEADBEEF. Required: m_addr=0x100, m_we=0, if_gnt in cycle 0, if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 1.
- Data priority and m_ready stall. Stimulus: if_req and d_req (store, addr 0x200, wdata 0x55) together; m_ready=0 for 3 cycles. Required: m_req=1 with m_addr=0x200, m_we=1 held for all 3 cycles; d_gnt on the 4th cycle; no if_gnt.
- Starvation. Stimulus: if_req held and d_req held continuously; STARVE_MAX=4. Required: 4 d_gnt pulses, then if_gnt, with d_req still high; starve_cnt returns to 0.
- Reset mid-transaction. Stimulus: d load accepted; rst_n=0 in WAIT_D; m_rvalid arrives the next cycle after release. Required: no d_rvalid; state IDLE.
- Spurious response. Stimulus: m_rvalid=1 in IDLE with no requests. Required: if_rvalid=d_rvalid=0; no state change.

Source files
------------

// File: rtl/mem_port_sched_pkg.sv
// mem_port_sched_pkg
//   Shared types and constants for the memory-port scheduler.
//   - sched_state_t : scheduler FSM states.
//   - MEM_*         : access-size encodings. These match the core's memsize
//                     field, which reuses RISC-V load/store funct3.
//   - WORD_SIZE     : the size code that instruction fetches always use.
//   - STARVE_W      : width of the starvation counter. It covers
//                     STARVE_MAX values up to 15.
package mem_port_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_I  = 3'd1,
    REQ_D  = 3'd2,
    WAIT_I = 3'd3,
    WAIT_D = 3'd4
  } sched_state_t;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [2:0] WORD_SIZE = MEM_W;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_sched_starve_cnt.sv
// sched_starve_cnt
//   Saturating counter. It counts data grants that are made while fetch is
//   kept waiting.
//   Ports:
//     clk, rst_n : clock and synchronous active-low reset
//     inc        : a data grant happened while fetch was requesting
//     clr        : a fetch grant happened; restart the count
//     hit        : the count has reached STARVE_MAX; fetch must win next
//     cnt        : current count (for debug visibility)
module sched_starve_cnt
  import mem_port_sched_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                clr,
  output logic                hit,
  output logic [STARVE_W-1:0] cnt
);

  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] CNT_ONE = STARVE_W'(1);

  // clr takes precedence over inc. The two never fire together, because
  // only one grant can happen per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign hit = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_sched.sv
// mem_port_sched
//   Arbitrates one shared memory port between instruction fetch (if_*) and
//   the load/store path (d_*). Only one transaction is in flight at a time.
//   Data has priority. A starvation counter forces fetch to win after
//   STARVE_MAX consecutive data grants made while fetch was waiting.
//
//   Handshake semantics (all interfaces):
//     A requester raises *_req together with its payload. It holds both
//     unchanged until it sees *_gnt, which is the cycle where
//     m_req & m_ready. Exactly one m_rvalid follows every accepted request,
//     reads and writes alike. That response is forwarded as a one-cycle
//     *_rvalid to the requester that owns the transaction. m_rvalid outside
//     a wait state and m_ready while m_req=0 carry no meaning and are
//     ignored.
//
//   Ports:
//     clk, rst_n           : clock, synchronous active-low reset
//     if_req/if_addr       : fetch request and address
//     if_gnt/if_rvalid     : fetch accept / response pulses
//     if_rdata             : fetch data; follows m_rdata on if_rvalid, else held
//     d_req/d_we/d_size    : data request, store flag, access size
//     d_addr/d_wdata       : data address and store data
//     d_gnt/d_rvalid       : data accept / response pulses
//     d_rdata              : load data; follows m_rdata on d_rvalid, else held
//     m_*                  : memory-side request, payload and response
//     dbg_state            : current FSM state
//     dbg_starve_cnt       : current starvation count
module mem_port_sched
  import mem_port_sched_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // fetch side
  input  logic                if_req,
  input  logic [XLEN-1:0]     if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [XLEN-1:0]     if_rdata,
  // load/store side
  input  logic                d_req,
  input  logic                d_we,
  input  logic [2:0]          d_size,
  input  logic [XLEN-1:0]     d_addr,
  input  logic [XLEN-1:0]     d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [XLEN-1:0]     d_rdata,
  // memory side
  output logic                m_req,
  output logic                m_we,
  output logic [2:0]          m_size,
  output logic [XLEN-1:0]     m_addr,
  output logic [XLEN-1:0]     m_wdata,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [XLEN-1:0]     m_rdata,
  // debug
  output sched_state_t        dbg_state,
  output logic [STARVE_W-1:0] dbg_starve_cnt
);

  sched_state_t state;
  sched_state_t state_next;

  // sel_i / sel_d: the requester whose payload drives the memory port in this cycle.
  logic sel_i;
  logic sel_d;
  logic starve_hit;

  logic [XLEN-1:0] if_rdata_q;
  logic [XLEN-1:0] d_rdata_q;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, selection and handshake pulses.
  // Everything is gated with rst_n so that no grant or response can leak out
  // while reset is held. Synchronous reset alone would let the IDLE
  // arbitration show through during the reset cycles.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    sel_i      = 1'b0;
    sel_d      = 1'b0;
    if_rvalid  = 1'b0;
    d_rvalid   = 1'b0;

    if (rst_n) begin
      unique case (state)
        IDLE: begin
          // Data wins unless fetch is waiting and has already been passed
          // over STARVE_MAX times.
          if (d_req && !(if_req && starve_hit)) begin
            sel_d      = 1'b1;
            state_next = m_ready ? WAIT_D : REQ_D;
          end else if (if_req) begin
            sel_i      = 1'b1;
            state_next = m_ready ? WAIT_I : REQ_I;
          end
        end
        // The winner stays latched while the memory stalls. A later request
        // from the other side cannot preempt it.
        REQ_I: begin
          sel_i = 1'b1;
          if (m_ready) state_next = WAIT_I;
        end
        REQ_D: begin
          sel_d = 1'b1;
          if (m_ready) state_next = WAIT_D;
        end
        // The response cycle returns to IDLE and issues nothing new. The
        // next request therefore goes out one cycle later.
        WAIT_I: begin
          if (m_rvalid) begin
            if_rvalid  = 1'b1;
            state_next = IDLE;
          end
        end
        WAIT_D: begin
          if (m_rvalid) begin
            d_rvalid   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign if_gnt = sel_i & m_ready;
  assign d_gnt  = sel_d & m_ready;

  // --------------------------------------------------------------------------
  // Payload mux. The port is driven to zero whenever no requester owns it.
  // --------------------------------------------------------------------------
  always_comb begin
    m_req   = sel_i | sel_d;
    m_we    = 1'b0;
    m_size  = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (sel_d) begin
      m_we    = d_we;
      m_size  = d_size;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (sel_i) begin
      m_size  = WORD_SIZE;
      m_addr  = if_addr;
    end
  end

  // --------------------------------------------------------------------------
  // Read data: combinational pass-through in the response cycle, otherwise
  // the last delivered value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_rvalid) if_rdata_q <= m_rdata;
      if (d_rvalid)  d_rdata_q  <= m_rdata;
    end
  end

  assign if_rdata = if_rvalid ? m_rdata : if_rdata_q;
  assign d_rdata  = d_rvalid  ? m_rdata : d_rdata_q;

  // --------------------------------------------------------------------------
  // Starvation tracking. Only data grants that pass over a waiting fetch
  // are counted.
  // --------------------------------------------------------------------------
  sched_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (d_gnt & if_req),
    .clr   (if_gnt),
    .hit   (starve_hit),
    .cnt   (dbg_starve_cnt)
  );

  assign dbg_state = state;

endmodule
